csa_pipe: RTL

- Parametrised, pipelined carry-select adder. It is the successor to the fixed 4-bit combinational carry-select adder.
- Splits a WIDTH-bit add into NUM_BLK = WIDTH/BLOCK carry-select blocks, with one register stage per block.
- Valid/ready handshake on input and output, with full backpressure.
- Sits between operand sources and datapath consumers that need high clock rate at arbitrary width.

---
 rtl/csa_pipe.sv | 130 +++++++++++++
 1 files changed

// File: rtl/csa_pipe.sv
// Pipelined carry-select adder: one BLOCK-bit carry-select block per register stage, valid/ready both ends.
// Define CSA_PIPE_OVF_EN to add the registered signed-overflow output Ovf.

module csa_blk #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co
);
  logic [BLOCK:0] r0, r1;

  // Both speculative sums are formed in parallel; the late carry only drives the mux.
  assign r0 = {1'b0, a} + {1'b0, b};
  assign r1 = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};
  assign {co, s} = ci ? r1 : r0;
endmodule

module csa_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef CSA_PIPE_OVF_EN
  ,
  output logic             Ovf
`endif
);
  localparam int NUM_BLK = (BLOCK > 0) ? WIDTH / BLOCK : 1;
  localparam int LAST    = NUM_BLK - 1;

  generate
    if (BLOCK < 1) begin : g_bad_block
      $error("csa_pipe: BLOCK must be at least 1");
    end else if ((WIDTH % BLOCK) != 0 || WIDTH < BLOCK) begin : g_bad_width
      $error("csa_pipe: WIDTH must be a non-zero multiple of BLOCK");
    end
  endgenerate

  logic [NUM_BLK-1:0]            vld_pipe, ld, src_v;
  logic [NUM_BLK-1:0]            st_c, src_c, co_blk;
  logic [NUM_BLK-1:0][WIDTH-1:0] st_a, st_b, src_a, src_b, nxt_a;
  logic [NUM_BLK-1:0][BLOCK-1:0] s_blk;
  logic                          unused_b;

  // Stage k resolves block k while loading, so the last stage holds the finished sum
  // and latency equals NUM_BLK. st_a carries resolved sum bits below, operand A above.
  genvar k;
  generate
    for (k = 0; k < NUM_BLK; k++) begin : g_stg
      localparam logic [WIDTH-1:0] MASK = (~({WIDTH{1'b1}} << BLOCK)) << (k * BLOCK);
      if (k == 0) begin : g_head
        assign src_a[k] = A;
        assign src_b[k] = B;
        assign src_c[k] = Cin;
        assign src_v[k] = in_valid;
      end else begin : g_link
        assign src_a[k] = st_a[k-1];
        assign src_b[k] = st_b[k-1];
        assign src_c[k] = st_c[k-1];
        assign src_v[k] = vld_pipe[k-1];
      end
      csa_blk #(.BLOCK(BLOCK)) u_blk (
        .a  (src_a[k][k*BLOCK +: BLOCK]),
        .b  (src_b[k][k*BLOCK +: BLOCK]),
        .ci (src_c[k]),
        .s  (s_blk[k]),
        .co (co_blk[k])
      );
      assign nxt_a[k] = (src_a[k] & ~MASK) | (WIDTH'(s_blk[k]) << (k * BLOCK));
    end
  endgenerate

  // A stage loads when empty or when its content moves on this cycle.
  always_comb begin
    ld = '0;
    ld[LAST] = !vld_pipe[LAST] || out_ready;
    for (int i = LAST - 1; i >= 0; i--) ld[i] = !vld_pipe[i] || ld[i+1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      st_a     <= '0;
      st_b     <= '0;
      st_c     <= '0;
    end else begin
      for (int i = 0; i < NUM_BLK; i++) begin
        if (ld[i]) begin
          vld_pipe[i] <= src_v[i];
          if (src_v[i]) begin
            st_a[i] <= nxt_a[i];
            st_b[i] <= src_b[i];
            st_c[i] <= co_blk[i];
          end
        end
      end
    end
  end

`ifdef CSA_PIPE_OVF_EN
  logic ovf_q;

  // Carry into the MSB is recovered as s^a^b at that bit; overflow when it differs from carry out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (ld[LAST] && src_v[LAST])
      ovf_q <= co_blk[LAST] ^ nxt_a[LAST][WIDTH-1] ^ src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1];
  end
  assign Ovf = ovf_q;
`endif

  assign unused_b  = ^st_b[LAST];
  assign in_ready  = ld[0];
  assign out_valid = vld_pipe[LAST];
  assign S         = st_a[LAST];
  assign Cout      = st_c[LAST];
endmodule
